// File: rtl/gpp_host_loader_pkg.sv
// Shared definitions for the GPP host loader: widths, FSM encoding and
// header field helpers.
package gpp_host_loader_pkg;

    localparam int D_WIDTH  = 32;
    localparam int SA_WIDTH = 10;
    localparam int DEPTH    = 2 ** SA_WIDTH;

    // Header word layout: low half is the load count, high half the readback count
    localparam int HDR_N_LSB = 0;
    localparam int HDR_N_W   = 16;
    localparam int HDR_R_LSB = 16;
    localparam int HDR_R_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_RUN      = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_RD_OUT   = 3'd5,
        ST_ERR      = 3'd6
    } gpp_state_e;

    function automatic logic [HDR_N_W-1:0] hdr_n(input logic [D_WIDTH-1:0] w);
        return w[HDR_N_LSB +: HDR_N_W];
    endfunction

    function automatic logic [HDR_R_W-1:0] hdr_r(input logic [D_WIDTH-1:0] w);
        return w[HDR_R_LSB +: HDR_R_W];
    endfunction

    // A header is rejected when the load image or the readback window would
    // run past the end of SRAM; this keeps all address arithmetic wrap-free.
    function automatic logic hdr_illegal(input logic [HDR_N_W-1:0] n,
                                         input logic [HDR_R_W-1:0] r,
                                         input int rb_base);
        return ({1'b0, n} > 17'(DEPTH)) || ({1'b0, r} > 17'(DEPTH - rb_base));
    endfunction

endpackage

// File: rtl/gpp_run_timer.sv
// RUN-phase watchdog: counts enabled cycles since the last clear and flags
// expiry so that the owner sees it on the TIMEOUT-th enabled cycle edge.
// TIMEOUT must be at least 2.
module gpp_run_timer #(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    // The flag is raised one count early because it is itself registered
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 2);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] r_count;
    logic          r_expired;

    // Cycle counter with saturating expiry flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count   <= '0;
            r_expired <= 1'b0;
        end else if (i_clear) begin
            r_count   <= '0;
            r_expired <= 1'b0;
        end else if (i_enable && !r_expired) begin
            r_count   <= r_count + ONE;
            r_expired <= (r_count == LAST);
        end else begin
            r_count   <= r_count;
            r_expired <= r_expired;
        end
    end

    assign o_expired = r_expired;

endmodule

// File: rtl/gpp_host_loader.sv
// Host-side front end owning SRAM port B of the GPP: loads an image from the
// host stream, runs the core until Done, then streams a result window back.
module gpp_host_loader
    import gpp_host_loader_pkg::*;
#(
    parameter logic [SA_WIDTH-1:0] RB_BASE = 10'h200,
    parameter int                  TIMEOUT = 1_000_000
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [D_WIDTH-1:0]  H_di,
    input  logic                H_valid,
    output logic                H_ready,
    output logic [D_WIDTH-1:0]  H_do,
    output logic                H_ovalid,
    input  logic                H_oready,
    output logic [D_WIDTH-1:0]  M_di,
    output logic [SA_WIDTH-1:0] MI_Addr,
    output logic                M_enb,
    output logic                M_web,
    output logic                Rst_M,
    input  logic [D_WIDTH-1:0]  MO_do,
    output logic                Core_Rst,
    input  logic                Done,
    output logic                Busy,
    output logic                Err
);

    gpp_state_e          r_state;
    logic [15:0]         r_n;
    logic [15:0]         r_r;
    logic [15:0]         r_cnt;
    logic                r_h_ready;
    logic                r_h_ovalid;
    logic [D_WIDTH-1:0]  r_h_do;
    logic [D_WIDTH-1:0]  r_m_di;
    logic [SA_WIDTH-1:0] r_mi_addr;
    logic                r_m_enb;
    logic                r_m_web;
    logic                r_rst_m;
    logic                r_core_rst;
    logic                r_busy;
    logic                r_err;

    logic                w_h_acc;
    logic                w_o_acc;
    logic                w_run;
    logic                w_expired;
    logic [15:0]         w_hdr_n;
    logic [15:0]         w_hdr_r;
    logic                w_hdr_bad;
    logic [15:0]         w_cnt_nxt;
    logic [SA_WIDTH-1:0] w_rb_addr_nxt;

    assign w_h_acc       = H_valid & r_h_ready;
    assign w_o_acc       = r_h_ovalid & H_oready;
    assign w_run         = (r_state == ST_RUN);
    assign w_hdr_n       = hdr_n(H_di);
    assign w_hdr_r       = hdr_r(H_di);
    assign w_hdr_bad     = hdr_illegal(w_hdr_n, w_hdr_r, int'(RB_BASE));
    assign w_cnt_nxt     = r_cnt + 16'd1;
    assign w_rb_addr_nxt = RB_BASE + w_cnt_nxt[SA_WIDTH-1:0];

    gpp_run_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_run_timer (
        .i_clk     (Clk),
        .i_rst_n   (Rst),
        .i_clear   (!w_run),
        .i_enable  (w_run),
        .o_expired (w_expired)
    );

    // Loader FSM with all host, SRAM and core-control outputs registered
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state    <= ST_IDLE;
            r_n        <= 16'd0;
            r_r        <= 16'd0;
            r_cnt      <= 16'd0;
            r_h_ready  <= 1'b0;
            r_h_ovalid <= 1'b0;
            r_h_do     <= '0;
            r_m_di     <= '0;
            r_mi_addr  <= '0;
            r_m_enb    <= 1'b0;
            r_m_web    <= 1'b0;
            r_rst_m    <= 1'b1;
            r_core_rst <= 1'b1;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // SRAM init is only held across reset; port B strobes are one-shot
            r_rst_m <= 1'b0;
            r_m_enb <= 1'b0;
            r_m_web <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_h_ready  <= 1'b1;
                    r_core_rst <= 1'b1;
                    r_h_ovalid <= 1'b0;
                    if (w_h_acc) begin
                        r_n    <= w_hdr_n;
                        r_r    <= w_hdr_r;
                        r_cnt  <= 16'd0;
                        r_busy <= 1'b1;
                        if (w_hdr_bad) begin
                            r_state   <= ST_ERR;
                            r_err     <= 1'b1;
                            r_h_ready <= 1'b0;
                        end else if (w_hdr_n == 16'd0) begin
                            r_state    <= ST_RUN;
                            r_h_ready  <= 1'b0;
                            r_core_rst <= 1'b0;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_h_acc) begin
                        r_m_enb   <= 1'b1;
                        r_m_web   <= 1'b1;
                        r_mi_addr <= r_cnt[SA_WIDTH-1:0];
                        r_m_di    <= H_di;
                        r_cnt     <= w_cnt_nxt;
                        if (w_cnt_nxt == r_n) begin
                            r_state    <= ST_RUN;
                            r_h_ready  <= 1'b0;
                            r_core_rst <= 1'b0;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end else begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_RUN: begin
                    // Done is checked first so it wins over a same-cycle timeout
                    if (Done) begin
                        r_core_rst <= 1'b1;
                        if (r_r == 16'd0) begin
                            r_state   <= ST_IDLE;
                            r_h_ready <= 1'b1;
                            r_busy    <= 1'b0;
                        end else begin
                            r_cnt     <= 16'd0;
                            r_state   <= ST_RD_ISSUE;
                            r_m_enb   <= 1'b1;
                            r_mi_addr <= RB_BASE;
                        end
                    end else if (w_expired) begin
                        r_state    <= ST_ERR;
                        r_err      <= 1'b1;
                        r_core_rst <= 1'b1;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RD_ISSUE: begin
                    r_state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    r_h_do     <= MO_do;
                    r_h_ovalid <= 1'b1;
                    r_state    <= ST_RD_OUT;
                end
                ST_RD_OUT: begin
                    if (w_o_acc) begin
                        r_h_ovalid <= 1'b0;
                        r_cnt      <= w_cnt_nxt;
                        if (w_cnt_nxt == r_r) begin
                            r_state   <= ST_IDLE;
                            r_h_ready <= 1'b1;
                            r_busy    <= 1'b0;
                        end else begin
                            r_state   <= ST_RD_ISSUE;
                            r_m_enb   <= 1'b1;
                            r_mi_addr <= w_rb_addr_nxt;
                        end
                    end else begin
                        r_state <= ST_RD_OUT;
                    end
                end
                ST_ERR: begin
                    r_err      <= 1'b1;
                    r_core_rst <= 1'b1;
                    r_h_ready  <= 1'b0;
                    r_h_ovalid <= 1'b0;
                end
                default: begin
                    r_state    <= ST_ERR;
                    r_err      <= 1'b1;
                    r_core_rst <= 1'b1;
                    r_h_ready  <= 1'b0;
                    r_h_ovalid <= 1'b0;
                end
            endcase
        end
    end

    assign H_ready  = r_h_ready;
    assign H_ovalid = r_h_ovalid;
    assign H_do     = r_h_do;
    assign M_di     = r_m_di;
    assign MI_Addr  = r_mi_addr;
    assign M_enb    = r_m_enb;
    assign M_web    = r_m_web;
    assign Rst_M    = r_rst_m;
    assign Core_Rst = r_core_rst;
    assign Busy     = r_busy;
    assign Err      = r_err;

endmodule

// File: tb/tb_gpp_host_loader.sv
// Scoreboard bench for gpp_host_loader with a behavioural SRAM port-B model.
module tb_gpp_host_loader;
    import gpp_host_loader_pkg::*;

    localparam int TMO = 50;

    logic                Clk = 1'b0;
    logic                Rst = 1'b1;
    logic [D_WIDTH-1:0]  H_di = '0;
    logic                H_valid = 1'b0;
    logic                H_ready;
    logic [D_WIDTH-1:0]  H_do;
    logic                H_ovalid;
    logic                H_oready = 1'b0;
    logic [D_WIDTH-1:0]  M_di;
    logic [SA_WIDTH-1:0] MI_Addr;
    logic                M_enb;
    logic                M_web;
    logic                Rst_M;
    logic [D_WIDTH-1:0]  MO_do;
    logic                Core_Rst;
    logic                Done = 1'b0;
    logic                Busy;
    logic                Err;

    gpp_host_loader #(
        .RB_BASE (10'h200),
        .TIMEOUT (TMO)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .H_di     (H_di),
        .H_valid  (H_valid),
        .H_ready  (H_ready),
        .H_do     (H_do),
        .H_ovalid (H_ovalid),
        .H_oready (H_oready),
        .M_di     (M_di),
        .MI_Addr  (MI_Addr),
        .M_enb    (M_enb),
        .M_web    (M_web),
        .Rst_M    (Rst_M),
        .MO_do    (MO_do),
        .Core_Rst (Core_Rst),
        .Done     (Done),
        .Busy     (Busy),
        .Err      (Err)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [41:0] exp_wr[$];
    logic [31:0] exp_rd[$];
    int          wr_stamp[$];
    logic        ovalid_seen = 1'b0;

    // SRAM model with one-cycle read latency and a bench backdoor write
    logic [31:0] mem [0:1023];
    logic        bd_en = 1'b0;
    logic [9:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (bd_en) mem[bd_addr] <= bd_data;
        else if (M_enb && M_web) mem[MI_Addr] <= M_di;
        if (M_enb && !M_web) MO_do <= mem[MI_Addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard monitor: SRAM writes and host readback handshakes
    always @(negedge Clk) begin
        logic [41:0] e;
        logic [31:0] r;
        if (Rst && M_enb && M_web) begin
            wr_stamp.push_back(cyc);
            if (exp_wr.size() == 0) chk("unexp_wr", 1'b1, 1'b0);
            else begin
                e = exp_wr.pop_front();
                chk("wr_addr", 64'(MI_Addr), 64'(e[41:32]));
                chk("wr_data", 64'(M_di), 64'(e[31:0]));
            end
        end
        if (Rst && H_ovalid) ovalid_seen = 1'b1;
        if (Rst && H_ovalid && H_oready) begin
            if (exp_rd.size() == 0) chk("unexp_rd", 1'b1, 1'b0);
            else begin
                r = exp_rd.pop_front();
                chk("rd_data", 64'(H_do), 64'(r));
            end
        end
    end

    task automatic send(input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        H_di = d;
        H_valid = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            if (H_ready) ok = 1'b1;
            else @(negedge Clk);
        end
        chk("send_accept", 64'(ok), 64'(1));
        if (ok) @(posedge Clk);
        @(negedge Clk);
        H_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget && Busy; k++) @(negedge Clk);
        chk("busy_low", 64'(Busy), 64'(0));
    endtask

    task automatic pulse_done();
        Done = 1'b1;
        @(negedge Clk);
        Done = 1'b0;
    endtask

    task automatic backdoor(input logic [9:0] a, input logic [31:0] d);
        bd_en = 1'b1; bd_addr = a; bd_data = d;
        @(negedge Clk);
        bd_en = 1'b0;
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        exp_wr.delete();
        exp_rd.delete();
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_h_ready"},  64'(H_ready),  64'(0));
        chk({p, "_h_ovalid"}, 64'(H_ovalid), 64'(0));
        chk({p, "_h_do"},     64'(H_do),     64'(0));
        chk({p, "_m_di"},     64'(M_di),     64'(0));
        chk({p, "_mi_addr"},  64'(MI_Addr),  64'(0));
        chk({p, "_m_enb"},    64'(M_enb),    64'(0));
        chk({p, "_m_web"},    64'(M_web),    64'(0));
        chk({p, "_rst_m"},    64'(Rst_M),    64'(1));
        chk({p, "_core_rst"}, 64'(Core_Rst), 64'(1));
        chk({p, "_busy"},     64'(Busy),     64'(0));
        chk({p, "_err"},      64'(Err),      64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] held;
        int k;
        #1 Rst = 1'b0;
        #2 check_reset_vals("rst");
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        chk("rst_m_low", 64'(Rst_M), 64'(0));
        chk("idle_ready", 64'(H_ready), 64'(1));

        // Done outside RUN has no effect
        pulse_done();
        @(negedge Clk);
        chk("done_idle_busy", 64'(Busy), 64'(0));
        chk("done_idle_core", 64'(Core_Rst), 64'(1));

        // Test 1: N=4, R=2, no stalls
        backdoor(10'h200, 32'hC0DE_0200);
        backdoor(10'h201, 32'hC0DE_0201);
        exp_rd.push_back(32'hC0DE_0200);
        exp_rd.push_back(32'hC0DE_0201);
        H_oready = 1'b1;
        wr_stamp.delete();
        send(32'h0002_0004);
        for (int i = 0; i < 4; i++) exp_wr.push_back({10'(i), 32'hA000_0000 + 32'(i)});
        for (int i = 0; i < 4; i++) send(32'hA000_0000 + 32'(i));
        chk("t1_core_run", 64'(Core_Rst), 64'(0));
        chk("t1_busy", 64'(Busy), 64'(1));
        chk("t1_ready_run", 64'(H_ready), 64'(0));
        @(negedge Clk);
        chk("t1_wr_count", 64'(wr_stamp.size()), 64'(4));
        if (wr_stamp.size() == 4) chk("t1_wr_span", 64'(wr_stamp[3] - wr_stamp[0]), 64'(3));
        for (int i = 0; i < 4; i++) chk("t1_mem", 64'(mem[i]), 64'(32'hA000_0000 + 32'(i)));
        repeat (4) @(negedge Clk);
        pulse_done();
        wait_idle(40);
        chk("t1_rd_left", 64'(exp_rd.size()), 64'(0));
        chk("t1_wr_left", 64'(exp_wr.size()), 64'(0));
        chk("t1_core_back", 64'(Core_Rst), 64'(1));

        // Test 2: same load with 2-cycle host gaps, no readback
        ovalid_seen = 1'b0;
        send(32'h0000_0004);
        for (int i = 0; i < 4; i++) exp_wr.push_back({10'(i), 32'hB000_0010 + 32'(i)});
        for (int i = 0; i < 4; i++) begin
            send(32'hB000_0010 + 32'(i));
            if (i < 3) begin
                @(negedge Clk);
                chk("t2_gap_enb", 64'(M_enb), 64'(0));
                @(negedge Clk);
                chk("t2_gap_enb", 64'(M_enb), 64'(0));
            end
        end
        @(negedge Clk);
        for (int i = 0; i < 4; i++) chk("t2_mem", 64'(mem[i]), 64'(32'hB000_0010 + 32'(i)));
        pulse_done();
        wait_idle(20);
        chk("t2_no_ovalid", 64'(ovalid_seen), 64'(0));

        // Test 3: empty header goes straight to RUN
        send(32'h0000_0000);
        chk("t3_core_run", 64'(Core_Rst), 64'(0));
        chk("t3_busy", 64'(Busy), 64'(1));
        pulse_done();
        wait_idle(20);
        chk("t3_no_ovalid", 64'(ovalid_seen), 64'(0));
        chk("t3_core_back", 64'(Core_Rst), 64'(1));

        // Test 4: readback with host back-pressure
        for (int i = 0; i < 3; i++) begin
            backdoor(10'h200 + 10'(i), 32'hD00D_0000 + 32'(i));
            exp_rd.push_back(32'hD00D_0000 + 32'(i));
        end
        H_oready = 1'b0;
        send(32'h0003_0001);
        exp_wr.push_back({10'd0, 32'hE000_0000});
        send(32'hE000_0000);
        pulse_done();
        for (k = 0; k < 20 && !H_ovalid; k++) @(negedge Clk);
        chk("t4_ovalid", 64'(H_ovalid), 64'(1));
        chk("t4_first", 64'(H_do), 64'(32'hD00D_0000));
        held = H_do;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("t4_hold_v", 64'(H_ovalid), 64'(1));
            chk("t4_hold_d", 64'(H_do), 64'(held));
        end
        H_oready = 1'b1;
        wait_idle(40);
        chk("t4_rd_left", 64'(exp_rd.size()), 64'(0));

        // Test 5: RUN timeout
        send(32'h0000_0000);
        k = 0;
        while (!Err && k < 200) begin
            @(negedge Clk);
            k++;
        end
        chk("t5_tmo_cycles", 64'(k), 64'(TMO));
        chk("t5_err", 64'(Err), 64'(1));
        chk("t5_core", 64'(Core_Rst), 64'(1));
        H_valid = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            chk("t5_ready_err", 64'(H_ready), 64'(0));
        end
        H_valid = 1'b0;
        do_reset();
        chk("t5_err_cleared", 64'(Err), 64'(0));

        // Test 6: oversize load count
        send(32'h0000_0401);
        chk("t6_err", 64'(Err), 64'(1));
        chk("t6_core", 64'(Core_Rst), 64'(1));
        repeat (3) begin
            @(negedge Clk);
            chk("t6_ready_err", 64'(H_ready), 64'(0));
        end
        do_reset();

        // Readback window one word too large
        send(32'h0201_0000);
        chk("t6b_err", 64'(Err), 64'(1));
        do_reset();

        // Test 7: async reset in the middle of a load
        send(32'h0000_0004);
        exp_wr.push_back({10'd0, 32'hF000_0000});
        exp_wr.push_back({10'd1, 32'hF000_0001});
        send(32'hF000_0000);
        send(32'hF000_0001);
        #1 Rst = 1'b0;
        #1 check_reset_vals("mid");
        chk("t7_wr_left", 64'(exp_wr.size()), 64'(0));
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gpp_host_loader.md
Name: gpp_host_loader

Overview:
Host-side front end that owns the SRAM B port of the GPP top level.
- Accepts a header plus a program/data image over a valid/ready stream and writes it sequentially into SRAM.
- Releases the GPP core from reset and waits for Done.
- Reads a result window back out of SRAM and streams it to the host.
- Sits directly upstream of the GPP top: it drives M_di, MI_Addr, M_enb, M_web, Rst_M and the core reset, and consumes MO_do and Done.

Parameters:
D_WIDTH, 32, data word width (shared define).
SA_WIDTH, 10, SRAM word-address width (shared define); DEPTH = 2**SA_WIDTH.
RB_BASE, 10'h200, first SRAM address of the readback window.
TIMEOUT, 1_000_000, maximum RUN cycles to wait for Done before the error state.

Ports:
Clk  in  1  system clock, rising edge.
Rst  in  1  asynchronous, active-low reset.
H_di  in  D_WIDTH  host input word.
H_valid  in  1  host input word valid.
H_ready  out  1  loader accepts H_di this cycle.
H_do  out  D_WIDTH  readback word to host.
H_ovalid  out  1  H_do valid.
H_oready  in  1  host accepts H_do.
M_di  out  D_WIDTH  SRAM port-B write data.
MI_Addr  out  SA_WIDTH  SRAM port-B address.
M_enb  out  1  SRAM port-B enable.
M_web  out  1  SRAM port-B write enable.
Rst_M  out  1  SRAM sinit, active-high.
MO_do  in  D_WIDTH  SRAM port-B read data, valid 1 cycle after the enabled read.
Core_Rst  out  1  GPP core reset, active-high.
Done  in  1  GPP core completion.
Busy  out  1  state != IDLE.
Err  out  1  sticky error flag.

Behaviour:
Reset values (Rst low, async): H_ready=0, H_ovalid=0, H_do=0, M_di=0, MI_Addr=0, M_enb=0, M_web=0, Rst_M=1, Core_Rst=1, Busy=0, Err=0, state=IDLE. All outputs are registered.
- Rst_M drops to 0 on the first clock after reset release and stays 0.

Header word fields: N = H_di[15:0] (load word count); R = H_di[31:16] (readback word count).
- A transfer occurs on H_valid & H_ready, and on H_ovalid & H_oready.

FSM:
- IDLE: H_ready=1, Core_Rst=1. On header accept, latch N, R and clear the address counter.
  - N > DEPTH or R > DEPTH-RB_BASE -> ERR.
  - N == 0 -> RUN.
  - Otherwise -> LOAD.
- LOAD: H_ready=1. Each accepted word produces, in the next cycle, M_enb=1, M_web=1, MI_Addr=cnt, M_di=word; then cnt++.
  - After the N-th word -> RUN.
  - Host stalls (H_valid=0) produce M_enb=0 for that cycle.
- RUN: Core_Rst=0, H_ready=0, timeout counter counts up.
  - Done==1 -> Core_Rst=1 next cycle; R==0 -> IDLE, else cnt=0 -> RD_ISSUE.
  - Counter reaching TIMEOUT -> ERR with Core_Rst=1.
- RD_ISSUE: M_enb=1, M_web=0, MI_Addr=RB_BASE+cnt -> RD_WAIT.
- RD_WAIT: capture MO_do into H_do, set H_ovalid=1 -> RD_OUT.
- RD_OUT: hold H_do and H_ovalid until H_oready; on the handshake H_ovalid=0, cnt++.
  - cnt == R -> IDLE, else -> RD_ISSUE.
  - Throughput: 1 word per 3 cycles minimum.
- ERR: Err=1, Core_Rst=1, H_ready=0, H_ovalid=0, no SRAM access. Exit only via Rst.

Boundary rules:
- Done outside RUN is ignored.
- Address arithmetic is SA_WIDTH wide; legal headers never wrap because of the header checks.
- Done and timeout in the same cycle: Done wins.
- H_valid during RUN or readback is not accepted.
- Reset mid-operation aborts immediately to the reset values; SRAM contents are undefined.

Decomposition:
- Shared package (define.h): D_WIDTH, SA_WIDTH, state encodings (IDLE=0, LOAD=1, RUN=2, RD_ISSUE=3, RD_WAIT=4, RD_OUT=5, ERR=6), header field positions.
- One natural sub-module: gpp_run_timer (RUN-phase timeout counter with clear/enable/expired).
- The loader FSM and datapath stay in gpp_host_loader. A new top instantiates gpp_host_loader beside GPP_TOP.

Test Plan:
- Header 0x0002_0004, 4 words A0..A3 with no stalls -> SRAM writes at 0..3 on consecutive cycles. Core_Rst falls. Done pulse -> H_do streams mem[0x200], mem[0x201]. Busy returns to 0.
- Same load with H_valid gaps of 2 cycles -> identical SRAM contents, M_enb low during the gaps.
- Header 0x0000_0000 -> RUN immediately. Done -> back to IDLE, no H_ovalid ever asserted.
- Header N=0x0401 with SA_WIDTH=10 -> Err=1 within 1 cycle, Core_Rst stays 1, H_ready=0 until Rst.
- TIMEOUT=50, Done never asserted -> Err=1 exactly 50 cycles after RUN entry, Core_Rst=1.
- Readback with H_oready low for 5 cycles -> H_do/H_ovalid stable throughout. Async Rst low mid-LOAD -> all outputs return to reset values within the same cycle.
